// File: rtl/instruction_fetch.sv
// Fetch sequencer: holds the PC, reads one instruction byte over a req/ack
// handshake, pulses load_ir for one cycle, then advances the PC.
module instruction_fetch #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instruction_in,
  output logic              load_ir,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              fetch_err
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_LOAD = 2'd2
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] instr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              mem_rd_q;
  logic              load_ir_q;
  logic              busy_q;
  logic              fetch_err_q;

  // State, PC and registered outputs; the output registers track the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      instr_q     <= '0;
      cnt_q       <= '0;
      mem_rd_q    <= 1'b0;
      load_ir_q   <= 1'b0;
      busy_q      <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      load_ir_q   <= 1'b0;
      fetch_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pc_load) begin
            pc_q <= pc_load_val;
          end else if (fetch_req) begin
            state_q  <= S_REQ;
            cnt_q    <= '0;
            mem_rd_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        S_REQ: begin
          // An ack on the last allowed REQ cycle still wins over the timeout.
          if (mem_ack) begin
            instr_q   <= mem_rdata;
            state_q   <= S_LOAD;
            mem_rd_q  <= 1'b0;
            load_ir_q <= 1'b1;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q     <= S_IDLE;
            mem_rd_q    <= 1'b0;
            busy_q      <= 1'b0;
            fetch_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_LOAD: begin
          pc_q    <= pc_q + ADDR_W'(1);
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= S_IDLE;
          mem_rd_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd         = mem_rd_q;
  assign mem_addr       = pc_q;
  assign pc_out         = pc_q;
  assign instruction_in = instr_q;
  assign load_ir        = load_ir_q;
  assign busy           = busy_q;
  assign fetch_err      = fetch_err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stimulus queues expected IR loads and
// fetch errors, a negedge monitor pops and checks them as the DUT pulses.
module tb_instruction_fetch;

  localparam int unsigned TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       fetch_req;
  logic       pc_load;
  logic [7:0] pc_load_val;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [7:0] instruction_in;
  logic       load_ir;
  logic [7:0] pc_out;
  logic       busy;
  logic       fetch_err;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] exp_pc;
  logic [7:0] exp_ir;

  instruction_fetch #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .fetch_req     (fetch_req),
    .pc_load       (pc_load),
    .pc_load_val   (pc_load_val),
    .mem_rd        (mem_rd),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instruction_in(instruction_in),
    .load_ir       (load_ir),
    .pc_out        (pc_out),
    .busy          (busy),
    .fetch_err     (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every load_ir / fetch_err pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (load_ir && fetch_err) chk("load_ir_and_err", 32'd1, 32'd0);
      if (load_ir || fetch_err) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, load_ir, fetch_err}, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("pulse_kind_err", {31'd0, fetch_err}, {31'd0, e.is_err});
          if (!e.is_err) chk("ir_data", {24'd0, instruction_in}, {24'd0, e.data});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit is_err, input logic [7:0] data);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    sb_q.push_back(e);
  endtask

  // One complete fetch from IDLE with the ack held off for dly REQ cycles.
  task automatic do_fetch(input logic [7:0] data, input int dly);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("req_mem_rd", {31'd0, mem_rd}, 32'd1);
    chk("req_mem_addr", {24'd0, mem_addr}, {24'd0, exp_pc});
    repeat (dly) tick();
    mem_ack   = 1'b1;
    mem_rdata = data;
    push(1'b0, data);
    tick();
    mem_ack = 1'b0;
    tick();
    exp_pc = exp_pc + 8'd1;
    exp_ir = data;
    chk("fetch_pc", {24'd0, pc_out}, {24'd0, exp_pc});
    chk("fetch_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; fetch_req = 1'b0; pc_load = 1'b0; pc_load_val = 8'h00;
    mem_ack = 1'b0; mem_rdata = 8'h00;
    exp_pc = 8'h00; exp_ir = 8'h00;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    chk("rst_pc", {24'd0, pc_out}, 32'd0);
    chk("rst_ir", {24'd0, instruction_in}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);

    // Basic fetch from PC 0
    do_fetch(8'h3C, 0);

    // Jump to 0xFF and wrap
    pc_load = 1'b1; pc_load_val = 8'hFF;
    tick();
    pc_load = 1'b0;
    exp_pc = 8'hFF;
    chk("jump_pc", {24'd0, pc_out}, 32'h0FF);
    do_fetch(8'hA5, 0);
    chk("wrap_pc", {24'd0, pc_out}, 32'h000);

    // Timeout: no ack for TIMEOUT REQ cycles
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    repeat (TIMEOUT - 1) tick();
    chk("to_still_waiting", {31'd0, mem_rd}, 32'd1);
    push(1'b1, 8'h00);
    tick();
    chk("to_err_pulse", {31'd0, fetch_err}, 32'd1);
    chk("to_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("to_busy", {31'd0, busy}, 32'd0);
    chk("to_pc", {24'd0, pc_out}, {24'd0, exp_pc});
    chk("to_ir", {24'd0, instruction_in}, {24'd0, exp_ir});
    tick();
    chk("to_err_single", {31'd0, fetch_err}, 32'd0);

    // Ack on the last allowed REQ cycle still succeeds
    do_fetch(8'h5A, TIMEOUT - 1);

    // pc_load / fetch_req during REQ and LOAD are ignored
    fetch_req = 1'b1;
    tick();
    chk("ign_mem_addr", {24'd0, mem_addr}, {24'd0, exp_pc});
    pc_load = 1'b1; pc_load_val = 8'h40;
    tick();
    mem_ack = 1'b1; mem_rdata = 8'h11;
    push(1'b0, 8'h11);
    tick();
    mem_ack = 1'b0;
    tick();
    pc_load = 1'b0; fetch_req = 1'b0;
    exp_pc = exp_pc + 8'd1;
    exp_ir = 8'h11;
    chk("ign_pc", {24'd0, pc_out}, {24'd0, exp_pc});
    chk("ign_busy", {31'd0, busy}, 32'd0);

    // pc_load beats fetch_req in IDLE; the fetch is dropped
    pc_load = 1'b1; fetch_req = 1'b1; pc_load_val = 8'h10;
    tick();
    pc_load = 1'b0; fetch_req = 1'b0;
    exp_pc = 8'h10;
    chk("both_pc", {24'd0, pc_out}, 32'h10);
    chk("both_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("both_no_rd", {31'd0, mem_rd}, 32'd0);

    // Back-to-back fetches from 0x10 with varied ack delay
    do_fetch(8'hC1, 0);
    do_fetch(8'hC2, 3);
    do_fetch(8'hC3, 5);
    do_fetch(8'hC4, 1);
    chk("b2b_pc", {24'd0, pc_out}, 32'h14);
    chk("b2b_ir", {24'd0, instruction_in}, 32'hC4);

    // Reset mid-REQ drops everything at once; a late ack is ignored
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("pre_rst_rd", {31'd0, mem_rd}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_pc", {24'd0, pc_out}, 32'd0);
    chk("arst_ir", {24'd0, instruction_in}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 8'h77;
    tick();
    tick();
    mem_ack = 1'b0;
    chk("late_ack_busy", {31'd0, busy}, 32'd0);
    chk("late_ack_ir", {24'd0, instruction_in}, 32'd0);
    tick();

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
